spike_scan_ctrl: RTL



---
 rtl/spike_scan_if.sv | 24 ++
 rtl/spike_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_scan_if.sv
// Bus and detector signal bundle for spike_scan_ctrl.
// master: CPU bus plus detector side; slave: the scan controller.
interface spike_scan_if;
    logic [3:0] address;
    logic       data_write;
    logic       data_read;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] det_pixel;
    logic       det_load;
    logic [7:0] det_threshold;
    logic       det_spike;
    logic       user_interrupt;

    modport master (
        output address, data_write, data_read, data_in, det_spike,
        input  data_out, det_pixel, det_load, det_threshold, user_interrupt
    );

    modport slave (
        input  address, data_write, data_read, data_in, det_spike,
        output data_out, det_pixel, det_load, det_threshold, user_interrupt
    );
endinterface

// File: rtl/spike_scan_ctrl.sv
// Frame-scan sequencer between the CPU register bus and the spike detector.
// Pixels written by the CPU are fed one at a time to the detector; spike
// events are queued as {col,row} for the CPU to read back.
// Optional feature macro: SPIKE_SCAN_IRQ_EN (interrupt enable bit and
// user_interrupt output; tied off when undefined).
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no pixel in flight
// S_LOAD   | det_load high, detector captures det_pixel, FIFO head popped
// S_SETTLE | waiting out the remaining detector latency
// S_SAMPLE | det_spike sampled, event pushed, position advanced
// S_STALL  | event FIFO full, event held until space appears
module spike_scan_ctrl #(
    parameter int COLS      = 16,
    parameter int PIX_DEPTH = 4,
    parameter int EVT_DEPTH = 4,
    parameter int DET_LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    spike_scan_if.slave  bus
);

    localparam int PW = (PIX_DEPTH > 1) ? $clog2(PIX_DEPTH) : 1;
    localparam int EW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int SW = (DET_LAT > 2) ? $clog2(DET_LAT - 1) : 1;
    localparam int SETTLE_INIT = (DET_LAT >= 2) ? DET_LAT - 2 : 0;
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_STALL
    } state_t;

    state_t state, state_nx;

    logic [7:0]    thresh;
    logic          en;
    logic          irq_en;
    logic          ovf;
    logic [7:0]    col, row, spike_cnt;
    logic [SW-1:0] settle_cnt;

    logic [7:0]    pix_mem [PIX_DEPTH];
    logic [PW-1:0] pix_wp, pix_rp;
    logic [PW:0]   pix_cnt;
    logic [7:0]    pix_head;
    logic          pix_empty, pix_full;

    logic [15:0]   evt_mem [EVT_DEPTH];
    logic [EW-1:0] evt_wp, evt_rp;
    logic [EW:0]   evt_cnt;
    logic [15:0]   evt_head;
    logic          evt_empty, evt_full;

    logic wr_pixel, wr_thresh, wr_ctrl, wr_status, clr;
    logic pix_push, pix_pop, pix_avail;
    logic evt_push, evt_pop, evt_space;
    logic event_hit, advance, busy;

    assign wr_pixel  = bus.data_write && (bus.address == 4'h0);
    assign wr_thresh = bus.data_write && (bus.address == 4'h1);
    assign wr_ctrl   = bus.data_write && (bus.address == 4'h2);
    assign wr_status = bus.data_write && (bus.address == 4'h3);
    assign clr       = wr_ctrl && bus.data_in[1];

    assign pix_empty = (pix_cnt == '0);
    assign pix_full  = (pix_cnt == (PW+1)'(PIX_DEPTH));
    assign pix_head  = pix_mem[pix_rp];
    assign evt_empty = (evt_cnt == '0);
    assign evt_full  = (evt_cnt == (EW+1)'(EVT_DEPTH));
    assign evt_head  = evt_mem[evt_rp];

    // The pop only ever happens in LOAD, so a full FIFO can still accept
    // a write in that cycle.
    assign pix_pop   = (state == S_LOAD);
    assign pix_push  = wr_pixel && (!pix_full || pix_pop);
    // A pixel arriving this cycle counts as available so an idle scanner
    // starts LOAD on the very next cycle.
    assign pix_avail = !pix_empty || pix_push;

    assign evt_pop   = bus.data_read && (bus.address == 4'h5) && !evt_empty;
    assign evt_space = !evt_full || evt_pop;
    // Column 0 compares against the previous row's last pixel, so it is
    // never a real edge.
    assign event_hit = bus.det_spike && (col != 8'd0);
    assign busy      = (state != S_IDLE);

    assign bus.det_threshold = thresh;

    // State register; CLR forces IDLE and drops any pixel in flight.
    always_ff @(posedge clk) begin
        if (rst)       state <= S_IDLE;
        else if (clr)  state <= S_IDLE;
        else           state <= state_nx;
    end

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nx = state;
        evt_push = 1'b0;
        advance  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && pix_avail) state_nx = S_LOAD;
            end
            S_LOAD: begin
                state_nx = (DET_LAT == 1) ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0) state_nx = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (event_hit && !evt_space) begin
                    state_nx = S_STALL;
                end else begin
                    evt_push = event_hit;
                    advance  = 1'b1;
                    state_nx = (en && pix_avail) ? S_LOAD : S_IDLE;
                end
            end
            S_STALL: begin
                if (evt_space) begin
                    evt_push = 1'b1;
                    advance  = 1'b1;
                    state_nx = (en && pix_avail) ? S_LOAD : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Settle down-counter, loaded while in LOAD.
    always_ff @(posedge clk) begin
        if (rst)                                      settle_cnt <= '0;
        else if (state == S_LOAD)                     settle_cnt <= SW'(SETTLE_INIT);
        else if (state == S_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
    end

    // Configuration registers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            thresh <= 8'd20;
            en     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (wr_thresh) thresh <= bus.data_in;
            if (wr_ctrl)   en     <= bus.data_in[0];
            if (clr || wr_status)        ovf <= 1'b0;
            else if (wr_pixel && !pix_push) ovf <= 1'b1;
        end
    end

`ifdef SPIKE_SCAN_IRQ_EN
    // Interrupt enable bit and registered level interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en             <= 1'b0;
            bus.user_interrupt <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus.data_in[2];
            bus.user_interrupt <= irq_en && !evt_empty;
        end
    end
`else
    assign irq_en             = 1'b0;
    assign bus.user_interrupt = 1'b0;
`endif

    // Pixel FIFO storage.
    always_ff @(posedge clk) begin
        if (pix_push) pix_mem[pix_wp] <= bus.data_in;
    end

    // Pixel FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pix_wp  <= '0;
            pix_rp  <= '0;
            pix_cnt <= '0;
        end else begin
            if (pix_push) pix_wp <= pix_wp + PW'(1);
            if (pix_pop)  pix_rp <= pix_rp + PW'(1);
            case ({pix_push, pix_pop})
                2'b10:   pix_cnt <= pix_cnt + (PW+1)'(1);
                2'b01:   pix_cnt <= pix_cnt - (PW+1)'(1);
                default: pix_cnt <= pix_cnt;
            endcase
        end
    end

    // Event FIFO storage.
    always_ff @(posedge clk) begin
        if (evt_push) evt_mem[evt_wp] <= {col, row};
    end

    // Event FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            evt_wp  <= '0;
            evt_rp  <= '0;
            evt_cnt <= '0;
        end else begin
            if (evt_push) evt_wp <= evt_wp + EW'(1);
            if (evt_pop)  evt_rp <= evt_rp + EW'(1);
            case ({evt_push, evt_pop})
                2'b10:   evt_cnt <= evt_cnt + (EW+1)'(1);
                2'b01:   evt_cnt <= evt_cnt - (EW+1)'(1);
                default: evt_cnt <= evt_cnt;
            endcase
        end
    end

    // Scan position and saturating event count.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col       <= 8'd0;
            row       <= 8'd0;
            spike_cnt <= 8'd0;
        end else begin
            if (advance) begin
                if (col == COL_LAST) begin
                    col <= 8'd0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
            if (evt_push && spike_cnt != 8'hFF) spike_cnt <= spike_cnt + 8'd1;
        end
    end

    // Detector drive; the pixel is captured on the edge entering LOAD,
    // straight from the bus when the FIFO is being filled this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.det_load  <= 1'b0;
            bus.det_pixel <= 8'd0;
        end else begin
            bus.det_load <= !clr && (state_nx == S_LOAD);
            if (!clr && state_nx == S_LOAD)
                bus.det_pixel <= pix_empty ? bus.data_in : pix_head;
        end
    end

    // Register read mux.
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.address)
            4'h1: bus.data_out = thresh;
            4'h2: bus.data_out = {5'b0, irq_en, 1'b0, en};
            4'h3: bus.data_out = {2'b0, busy, ovf, evt_full, !evt_empty, pix_full, pix_empty};
            4'h4: bus.data_out = evt_empty ? 8'h00 : evt_head[15:8];
            4'h5: bus.data_out = evt_empty ? 8'h00 : evt_head[7:0];
            4'h6: bus.data_out = col;
            4'h7: bus.data_out = row;
            4'h8: bus.data_out = spike_cnt;
            default: bus.data_out = 8'h00;
        endcase
    end

endmodule
